// File: rtl/rcv_fifo_ctrl.sv
// Byte-to-word receive FIFO: packs BPW bytes per word, frames on eop, sticky error flags.
// Optional almost_full output enabled by defining RCV_FIFO_ALMOST_FULL_EN.
module rcv_fifo_ctrl #(
  parameter int BPW   = 4,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  input  logic                   eop,
  input  logic                   rd_en,
  input  logic                   clear_err,
  output logic [8*BPW-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   framing_error,
`ifdef RCV_FIFO_ALMOST_FULL_EN
  output logic                   almost_full,
`endif
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = (BPW > 1) ? $clog2(BPW) : 1;

  logic [AW-1:0]         head_ptr, tail_ptr;
  logic                  head_tog, tail_tog;
  logic [SW-1:0]         tail_side;
  logic [BPW-1:0][7:0]   asm_q, asm_next;
  logic [BPW-1:0]        lane_hit;
  logic [8*BPW-1:0]      mem [DEPTH];

  logic accept, last_lane, commit, eop_err, pop, drop;

  assign full      = (head_ptr == tail_ptr) && (head_tog != tail_tog);
  assign empty     = (head_ptr == tail_ptr) && (head_tog == tail_tog) && (tail_side == '0);
  assign accept    = wr_en && !full;
  assign drop      = wr_en && full;
  assign last_lane = (tail_side == SW'(BPW-1));
  assign commit    = accept && last_lane;
  assign eop_err   = accept && eop && !last_lane;
  assign pop       = rd_en && (count != '0);
  assign rd_data   = mem[head_ptr];

`ifdef RCV_FIFO_ALMOST_FULL_EN
  assign almost_full = (count >= (AW+1)'(DEPTH-1));
`endif

  // Committed word takes the incoming byte directly in its lane, so the
  // last byte never has to round-trip through the assembly register.
  for (genvar k = 0; k < BPW; k++) begin : g_lane
    assign lane_hit[k] = accept && (tail_side == SW'(k));
    assign asm_next[k] = lane_hit[k] ? wr_data : asm_q[k];

    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)           asm_q[k] <= '0;
      else if (lane_hit[k]) asm_q[k] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (commit) mem[tail_ptr] <= asm_next;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      head_ptr      <= '0;
      head_tog      <= 1'b0;
      tail_ptr      <= '0;
      tail_tog      <= 1'b0;
      tail_side     <= '0;
      count         <= '0;
      framing_error <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      // Pointer plus toggle behaves as one AW+1 bit counter since DEPTH is a power of 2.
      if (commit) {tail_tog, tail_ptr} <= {tail_tog, tail_ptr} + 1'b1;
      if (pop)    {head_tog, head_ptr} <= {head_tog, head_ptr} + 1'b1;

      if (accept) tail_side <= (last_lane || eop) ? '0 : tail_side + SW'(1);

      if (commit && !pop)      count <= count + 1'b1;
      else if (pop && !commit) count <= count - 1'b1;

      if (eop_err)        framing_error <= 1'b1;
      else if (clear_err) framing_error <= 1'b0;

      if (drop)           overflow <= 1'b1;
      else if (clear_err) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rcv_fifo_ctrl.sv
// Directed bench for rcv_fifo_ctrl with BPW=4, DEPTH=4.
module tb_rcv_fifo_ctrl;
  localparam int BPW = 4, DEPTH = 4;

  logic        clk = 0, n_rst = 0;
  logic        wr_en = 0, eop = 0, rd_en = 0, clear_err = 0;
  logic [7:0]  wr_data = 0;
  logic [31:0] rd_data;
  logic        full, empty, framing_error, overflow;
  logic [2:0]  count;
`ifdef RCV_FIFO_ALMOST_FULL_EN
  logic        almost_full;
`endif

  int vecs = 0, errs = 0;

  rcv_fifo_ctrl #(.BPW(BPW), .DEPTH(DEPTH)) dut (
    .clk(clk), .n_rst(n_rst), .wr_en(wr_en), .wr_data(wr_data), .eop(eop),
    .rd_en(rd_en), .clear_err(clear_err), .rd_data(rd_data), .full(full),
    .empty(empty), .count(count), .framing_error(framing_error),
`ifdef RCV_FIFO_ALMOST_FULL_EN
    .almost_full(almost_full),
`endif
    .overflow(overflow));

  always #5 clk = ~clk;

  task automatic step(input logic w, input logic [7:0] d, input logic e,
                      input logic r, input logic c);
    @(negedge clk);
    wr_en = w; wr_data = d; eop = e; rd_en = r; clear_err = c;
    @(posedge clk); #1;
    wr_en = 0; eop = 0; rd_en = 0; clear_err = 0;
  endtask

  task automatic put_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) step(1, w[8*i +: 8], 0, 0, 0);
  endtask

  function automatic logic [31:0] word_of(input logic [7:0] b);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  task automatic test_reset();
    n_rst = 0;
    #12;
    vecs++;
    if ({empty, full, count, framing_error, overflow} !== 7'b1_0_000_0_0) begin
      errs++;
      $display("FAIL reset_state: got e=%b f=%b c=%0d fe=%b ov=%b, want e=1 f=0 c=0 fe=0 ov=0",
               empty, full, count, framing_error, overflow);
    end
    @(negedge clk); n_rst = 1;
  endtask

  task automatic test_basic();
    step(1, 8'h11, 0, 0, 0);
    step(1, 8'h22, 0, 0, 0);
    step(1, 8'h33, 0, 0, 0);
    vecs++;
    if (empty !== 1'b0 || count !== 3'd0) begin
      errs++; $display("FAIL partial_not_empty: got e=%b c=%0d, want e=0 c=0", empty, count);
    end
    step(1, 8'h44, 0, 0, 0);
    vecs++;
    if (count !== 3'd1 || empty !== 1'b0 || rd_data !== 32'h44332211) begin
      errs++; $display("FAIL basic_commit: got c=%0d e=%b d=%h, want c=1 e=0 d=44332211",
                       count, empty, rd_data);
    end
    step(0, 0, 0, 1, 0);
    vecs++;
    if (count !== 3'd0 || empty !== 1'b1) begin
      errs++; $display("FAIL basic_pop: got c=%0d e=%b, want c=0 e=1", count, empty);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) step(1, 8'(i + 1), 0, 0, 0);
    vecs++;
    if (full !== 1'b1 || count !== 3'd4 || rd_data !== 32'h04030201) begin
      errs++; $display("FAIL fill_full: got f=%b c=%0d d=%h, want f=1 c=4 d=04030201",
                       full, count, rd_data);
    end
    step(1, 8'hEE, 0, 0, 0);
    vecs++;
    if (overflow !== 1'b1 || count !== 3'd4 || full !== 1'b1 || rd_data !== 32'h04030201) begin
      errs++; $display("FAIL overflow_set: got ov=%b c=%0d f=%b d=%h, want ov=1 c=4 f=1 d=04030201",
                       overflow, count, full, rd_data);
    end
    step(1, 8'hEF, 0, 0, 1);
    vecs++;
    if (overflow !== 1'b1) begin
      errs++; $display("FAIL overflow_set_beats_clear: got ov=%b, want 1", overflow);
    end
    step(0, 0, 0, 0, 1);
    vecs++;
    if (overflow !== 1'b0) begin
      errs++; $display("FAIL overflow_clear: got ov=%b, want 0", overflow);
    end
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (rd_data !== word_of(8'(4*i + 1))) begin
        errs++; $display("FAIL overflow_contents[%0d]: got %h, want %h", i, rd_data, word_of(8'(4*i + 1)));
      end
      step(0, 0, 0, 1, 0);
    end
    vecs++;
    if (empty !== 1'b1 || count !== 3'd0) begin
      errs++; $display("FAIL overflow_drain: got e=%b c=%0d, want e=1 c=0", empty, count);
    end
  endtask

  task automatic test_framing();
    step(1, 8'hAA, 0, 0, 0);
    step(1, 8'hBB, 1, 0, 0);
    vecs++;
    if (framing_error !== 1'b1 || empty !== 1'b1 || count !== 3'd0) begin
      errs++; $display("FAIL framing_short: got fe=%b e=%b c=%0d, want fe=1 e=1 c=0",
                       framing_error, empty, count);
    end
    step(1, 8'h01, 0, 0, 0);
    step(1, 8'h02, 0, 0, 0);
    step(1, 8'h03, 0, 0, 0);
    step(1, 8'h04, 1, 0, 0);
    vecs++;
    if (count !== 3'd1 || rd_data !== 32'h04030201 || framing_error !== 1'b1) begin
      errs++; $display("FAIL framing_aligned_eop: got c=%0d d=%h fe=%b, want c=1 d=04030201 fe=1",
                       count, rd_data, framing_error);
    end
    step(0, 0, 0, 1, 1);
    vecs++;
    if (framing_error !== 1'b0 || empty !== 1'b1) begin
      errs++; $display("FAIL framing_clear: got fe=%b e=%b, want fe=0 e=1", framing_error, empty);
    end
  endtask

  task automatic test_back_to_back();
    put_word(word_of(8'h20));
    put_word(word_of(8'h30));
    step(1, 8'h40, 0, 0, 0);
    step(1, 8'h41, 0, 0, 0);
    step(1, 8'h42, 0, 0, 0);
    step(1, 8'h43, 0, 1, 0);
    vecs++;
    if (count !== 3'd2 || rd_data !== word_of(8'h30)) begin
      errs++; $display("FAIL commit_and_pop: got c=%0d d=%h, want c=2 d=%h", count, rd_data, word_of(8'h30));
    end
    step(0, 0, 0, 1, 0);
    vecs++;
    if (count !== 3'd1 || rd_data !== word_of(8'h40)) begin
      errs++; $display("FAIL commit_and_pop_next: got c=%0d d=%h, want c=1 d=%h", count, rd_data, word_of(8'h40));
    end
    step(0, 0, 0, 1, 0);
  endtask

  task automatic test_wrap();
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 4; i++) put_word(word_of(8'(8'h80 + 16*pass + 4*i)));
      vecs++;
      if (full !== 1'b1 || count !== 3'd4) begin
        errs++; $display("FAIL wrap_full[%0d]: got f=%b c=%0d, want f=1 c=4", pass, full, count);
      end
      for (int i = 0; i < 4; i++) begin
        vecs++;
        if (rd_data !== word_of(8'(8'h80 + 16*pass + 4*i))) begin
          errs++; $display("FAIL wrap_order[%0d][%0d]: got %h, want %h", pass, i, rd_data,
                           word_of(8'(8'h80 + 16*pass + 4*i)));
        end
        step(0, 0, 0, 1, 0);
      end
    end
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    vecs++;
    if (empty !== 1'b1 || count !== 3'd0 || full !== 1'b0) begin
      errs++; $display("FAIL empty_read_ignored: got e=%b c=%0d f=%b, want e=1 c=0 f=0", empty, count, full);
    end
    put_word(32'hCAFEF00D);
    vecs++;
    if (count !== 3'd1 || rd_data !== 32'hCAFEF00D) begin
      errs++; $display("FAIL empty_read_head_kept: got c=%0d d=%h, want c=1 d=cafef00d", count, rd_data);
    end
    step(0, 0, 0, 1, 0);
  endtask

  task automatic test_async_reset();
    put_word(word_of(8'h50));
    put_word(word_of(8'h54));
    put_word(word_of(8'h58));
    step(1, 8'h5C, 0, 0, 0);
    step(1, 8'h5D, 1, 0, 0);
    step(1, 8'h60, 0, 0, 0);
    step(1, 8'h61, 0, 0, 0);
`ifdef RCV_FIFO_ALMOST_FULL_EN
    vecs++;
    if (almost_full !== 1'b1) begin
      errs++; $display("FAIL almost_full_set: got %b, want 1", almost_full);
    end
`endif
    vecs++;
    if (count !== 3'd3 || framing_error !== 1'b1) begin
      errs++; $display("FAIL pre_reset_state: got c=%0d fe=%b, want c=3 fe=1", count, framing_error);
    end
    @(negedge clk); #2;
    n_rst = 0;
    #1;
    vecs++;
    if ({empty, full, count, framing_error, overflow} !== 7'b1_0_000_0_0) begin
      errs++; $display("FAIL async_reset: got e=%b f=%b c=%0d fe=%b ov=%b, want e=1 f=0 c=0 fe=0 ov=0",
                       empty, full, count, framing_error, overflow);
    end
`ifdef RCV_FIFO_ALMOST_FULL_EN
    vecs++;
    if (almost_full !== 1'b0) begin
      errs++; $display("FAIL almost_full_reset: got %b, want 0", almost_full);
    end
`endif
    @(negedge clk); n_rst = 1;
    put_word(32'h12345678);
    vecs++;
    if (count !== 3'd1 || rd_data !== 32'h12345678) begin
      errs++; $display("FAIL post_reset_write: got c=%0d d=%h, want c=1 d=12345678", count, rd_data);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_framing();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rcv_fifo_ctrl.md
RCV_FIFO_CTRL -- requirements
Module: rcv_fifo_ctrl

Interface
REQ-001: Parameter BPW, default 4, bytes per FIFO word (>=1).
REQ-002: Parameter DEPTH, default 8, words of storage (power of 2, >=2).
REQ-003: clk  input  1  single clock; all state updates on rising edge.
REQ-004: n_rst  input  1  asynchronous, active-low reset.
REQ-005: wr_en  input  1  byte write strobe.
REQ-006: wr_data  input  8  received byte.
REQ-007: eop  input  1  end-of-frame marker, qualified by wr_en, tags the byte written that cycle.
REQ-008: rd_en  input  1  word pop request.
REQ-009: rd_data  output  8*BPW  word at head (show-ahead); byte k of the word in bits [8k+7:8k].
REQ-010: full  output  1  DEPTH committed words stored.
REQ-011: empty  output  1  no committed words and no partial bytes.
REQ-012: count  output  clog2(DEPTH)+1  committed word count, 0..DEPTH.
REQ-013: framing_error  output  1  sticky; frame ended on a partial word.
REQ-014: overflow  output  1  sticky; a byte was dropped because the FIFO was full.
REQ-015: clear_err  input  1  synchronous clear of framing_error and overflow.

Function
REQ-016: The tail pointer and head pointer SHALL each be clog2(DEPTH) bits, plus one toggle bit that flips on pointer wrap DEPTH-1 -> 0.
REQ-017: tail_side (0..BPW-1) SHALL count the bytes held in the assembly register; a byte written with wr_en=1 while full=0 SHALL be placed in lane tail_side.
REQ-018: When an accepted byte lands in lane BPW-1, the assembled word SHALL be committed to mem[tail_ptr], tail_ptr SHALL advance, and tail_side SHALL return to 0, all in the same cycle.
REQ-019: full = (head_ptr==tail_ptr) and (head_tog!=tail_tog); empty = (head_ptr==tail_ptr) and (head_tog==tail_tog) and (tail_side==0); both combinational from registered state.
REQ-020: A byte with wr_en=1 while full=1 SHALL be dropped without changing tail_side or mem, and SHALL set overflow.
REQ-021: rd_en=1 with at least one committed word SHALL advance head_ptr; rd_en with zero committed words SHALL be ignored, with no state change.
REQ-022: A read SHALL NOT unblock a write in the same cycle; full is evaluated on pre-edge state.
REQ-023: For an accepted byte with eop=1 landing in lane BPW-1, the word SHALL commit normally with no error.
REQ-024: For an accepted byte with eop=1 landing in any other lane, framing_error SHALL be set, the partial word SHALL be discarded, and tail_side SHALL reset to 0.
REQ-025: count SHALL be incremented on a commit, decremented on a pop, and held when a commit and a pop occur in the same cycle.
REQ-026: clear_err=1 SHALL clear both sticky flags, except that a flag set in the same cycle SHALL win and remain 1.
REQ-027: rd_data SHALL equal mem[head_ptr] combinationally; when no committed word is present, its value is don't-care.

Reset
REQ-028: On n_rst=0, the following SHALL be cleared asynchronously: pointers, toggles, tail_side, count, framing_error, overflow, and the assembly register.
REQ-029: After reset, empty=1, full=0, count=0, framing_error=0, overflow=0; mem contents are not reset.
REQ-030: Reset asserted mid-frame SHALL discard all stored and partial data.

Configuration
REQ-031: With RCV_FIFO_ALMOST_FULL_EN defined, an output almost_full (1 bit) SHALL exist, equal to (count >= DEPTH-1), and reset to 0.
REQ-032: Without RCV_FIFO_ALMOST_FULL_EN, the almost_full port and its logic SHALL be absent; all other behaviour is unchanged.

Verification (BPW=4, DEPTH=4)
REQ-033: Write bytes 11,22,33,44 -> after the 4th edge count=1, empty=0, rd_data=0x44332211.
REQ-034: Write 16 bytes, then a 17th byte -> full=1 and count=4 after byte 16; byte 17 sets overflow=1 and the contents are unchanged; clear_err then clears overflow.
REQ-035: Write AA,BB with eop=1 on BB -> framing_error=1, tail_side=0, empty=1, count=0.
REQ-036: Hold the FIFO at count=2 with tail_side=3; in one cycle commit a word and pop a word -> count stays 2 and the head word advances.
REQ-037: Fill 4 words, pop 4, refill 4 -> pointers wrap, toggles flip, and data order is preserved; rd_en while empty causes no change.
REQ-038: Assert n_rst with tail_side=2 and count=3 -> all outputs return to reset values immediately, without waiting for a clock edge.
